// File: rtl/fifo_seq_pkg.sv
// Shared mode encodings and defaults for the FIFO sequencer.
package fifo_seq_pkg;

   localparam logic [1:0] S_MANUAL = 2'd0;
   localparam logic [1:0] S_AUTO   = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;

   localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioning: 2-FF synchroniser, counter debounce, and a one-cycle
// press pulse on the rising edge of the debounced level.
module btn_conditioner #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic             sync_p0;
   logic             sync_p1;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         level_d <= level;
         // Any cycle where the synchronised value matches the level restarts the count.
         if (sync_p1 != level) begin
            if (cnt == CNT_W'(DB_CYCLES - 1)) begin
               level <= sync_p1;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/fifo_sequencer.sv
// Turns UART strobes and buttons into gated FIFO write/read pulses; runs the
// manual, auto and flush read modes and counts dropped writes and underruns.
module fifo_sequencer
   import fifo_seq_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int CW        = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          rx_valid,
   input  logic          btn_wr,
   input  logic          btn_rd,
   input  logic          btn_auto,
   input  logic          tick,
   input  logic          full,
   input  logic          empty,
   output logic          wReq,
   output logic          rReq,
   output logic [1:0]    state,
   output logic [CW-1:0] drop_cnt,
   output logic [CW-1:0] underrun_cnt
);

   logic wr_level, wr_press;
   logic rd_level, rd_press;
   logic auto_level_unused, auto_press;
   logic both_d;
   logic flush_entry;
   logic wr_ev;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_wr (
      .clk(CLK), .rst(RST), .btn(btn_wr), .level(wr_level), .press(wr_press)
   );
   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_rd (
      .clk(CLK), .rst(RST), .btn(btn_rd), .level(rd_level), .press(rd_press)
   );
   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_auto (
      .clk(CLK), .rst(RST), .btn(btn_auto), .level(auto_level_unused), .press(auto_press)
   );

   // The wr+rd chord consumes both presses on its entry cycle.
   assign flush_entry = wr_level & rd_level & ~both_d & (state != S_FLUSH);
   assign wr_ev       = rx_valid | (wr_press & ~flush_entry);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_MANUAL;
         wReq         <= 1'b0;
         rReq         <= 1'b0;
         drop_cnt     <= '0;
         underrun_cnt <= '0;
         both_d       <= 1'b0;
      end else begin
         both_d <= wr_level & rd_level;
         wReq   <= 1'b0;
         rReq   <= 1'b0;

         if (wr_ev) begin
            if (state == S_FLUSH || full) drop_cnt <= sat_inc(drop_cnt);
            else                          wReq     <= 1'b1;
         end

         case (state)
            S_MANUAL: begin
               if (flush_entry) begin
                  state <= S_FLUSH;
               end else begin
                  if (auto_press) state <= S_AUTO;
                  if (rd_press) begin
                     if (!empty) rReq         <= 1'b1;
                     else        underrun_cnt <= sat_inc(underrun_cnt);
                  end
               end
            end
            S_AUTO: begin
               if (flush_entry) begin
                  state <= S_FLUSH;
               end else begin
                  if (auto_press) state <= S_MANUAL;
                  if (tick && !empty) rReq <= 1'b1;
               end
            end
            S_FLUSH: begin
               // Cycles with rReq high are skipped so the FIFO's registered empty flag reflects the last read.
               if (!rReq) begin
                  if (empty) state <= S_MANUAL;
                  else       rReq  <= 1'b1;
               end
            end
            default: state <= S_MANUAL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_sequencer.sv
// Self-checking bench for fifo_sequencer with a small FIFO occupancy model.
module tb_fifo_sequencer;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic rx_valid = 1'b0, btn_wr = 1'b0, btn_rd = 1'b0, btn_auto = 1'b0, tick = 1'b0;
   logic full_force = 1'b0, empty_force = 1'b1, use_model = 1'b0;
   logic full, empty;
   int   m_cnt = 0;
   localparam int DEPTH = 4;

   logic       wReq, rReq, wReq2, rReq2;
   logic [1:0] state, state2;
   logic [7:0] drop_cnt, underrun_cnt;
   logic [1:0] drop2, under2;

   int checks = 0;
   int errors = 0;
   int exp_drop = 0;
   int exp_under = 0;

   assign empty = use_model ? (m_cnt == 0) : empty_force;
   assign full  = use_model ? (m_cnt == DEPTH) : full_force;

   always #5 CLK = ~CLK;

   // Behavioural FIFO occupancy: one entry per accepted write, minus one per read of a non-empty FIFO.
   always @(posedge CLK) begin
      if (RST) m_cnt <= 0;
      else     m_cnt <= m_cnt + ((wReq && m_cnt < DEPTH) ? 1 : 0) - ((rReq && m_cnt > 0) ? 1 : 0);
   end

   fifo_sequencer #(.DB_CYCLES(4), .CW(8)) dut (
      .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .btn_wr(btn_wr), .btn_rd(btn_rd),
      .btn_auto(btn_auto), .tick(tick), .full(full), .empty(empty), .wReq(wReq),
      .rReq(rReq), .state(state), .drop_cnt(drop_cnt), .underrun_cnt(underrun_cnt)
   );

   fifo_sequencer #(.DB_CYCLES(4), .CW(2)) dut2 (
      .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .btn_wr(btn_wr), .btn_rd(btn_rd),
      .btn_auto(btn_auto), .tick(tick), .full(full), .empty(empty), .wReq(wReq2),
      .rReq(rReq2), .state(state2), .drop_cnt(drop2), .underrun_cnt(under2)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      exp_drop = 0;
      exp_under = 0;
   endtask

   task automatic test_reset();
      do_reset();
      use_model = 1'b0;
      full_force = 1'b1;
      rx_valid = 1'b1;
      step();
      step();
      checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL pre_reset_drop: got %0d expected 2", drop_cnt); end
      RST = 1'b1;
      step();
      step();
      checks++; if (wReq !== 1'b0 || rReq !== 1'b0) begin errors++; $display("FAIL reset_req: got w=%b r=%b expected 0 0", wReq, rReq); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (drop_cnt !== 8'd0 || underrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d %0d expected 0 0", drop_cnt, underrun_cnt); end
      checks++; if (drop2 !== 2'd0) begin errors++; $display("FAIL reset_drop2: got %0d expected 0", drop2); end
      RST = 1'b0;
      rx_valid = 1'b0;
      full_force = 1'b0;
      exp_drop = 0;
      exp_under = 0;
      step();
   endtask

   task automatic test_write_path();
      full_force = 1'b0;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      checks++; if (wReq !== 1'b1) begin errors++; $display("FAIL wreq_t1: got %b expected 1", wReq); end
      step();
      checks++; if (wReq !== 1'b0) begin errors++; $display("FAIL wreq_t2: got %b expected 0", wReq); end
      full_force = 1'b1;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      exp_drop++;
      checks++; if (wReq !== 1'b0) begin errors++; $display("FAIL wreq_full: got %b expected 0", wReq); end
      checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL drop_full: got %0d expected %0d", drop_cnt, exp_drop); end
      full_force = 1'b0;
      step();
   endtask

   task automatic test_random_writes();
      logic r, f;
      int   d2;
      do_reset();
      d2 = 0;
      for (int i = 0; i < 300; i++) begin
         r = 1'($urandom_range(0, 1));
         f = ($urandom_range(0, 9) < 3);
         rx_valid = r;
         full_force = f;
         step();
         if (r && f) begin
            if (exp_drop < 255) exp_drop++;
            if (d2 < 3) d2++;
         end
         checks++; if (wReq !== (r & ~f)) begin errors++; $display("FAIL rand_wreq[%0d]: got %b expected %b", i, wReq, r & ~f); end
      end
      rx_valid = 1'b0;
      full_force = 1'b0;
      step();
      checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d expected %0d", drop_cnt, exp_drop); end
      checks++; if (drop2 !== 2'(d2)) begin errors++; $display("FAIL rand_drop2: got %0d expected %0d", drop2, d2); end
   endtask

   task automatic test_button_read();
      int n;
      do_reset();
      empty_force = 1'b0;
      n = 0;
      btn_rd = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); n += int'(rReq); end
      btn_rd = 1'b0;
      for (int i = 0; i < 15; i++) begin step(); n += int'(rReq); end
      checks++; if (n != 0) begin errors++; $display("FAIL bounce_rreq: got %0d pulses expected 0", n); end
      n = 0;
      btn_rd = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); n += int'(rReq); end
      btn_rd = 1'b0;
      for (int i = 0; i < 15; i++) begin step(); n += int'(rReq); end
      checks++; if (n != 1) begin errors++; $display("FAIL hold_rreq: got %0d pulses expected 1", n); end
      empty_force = 1'b1;
      n = 0;
      btn_rd = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); n += int'(rReq); end
      btn_rd = 1'b0;
      for (int i = 0; i < 15; i++) begin step(); n += int'(rReq); end
      exp_under++;
      checks++; if (n != 0) begin errors++; $display("FAIL underrun_rreq: got %0d pulses expected 0", n); end
      checks++; if (underrun_cnt !== 8'(exp_under)) begin errors++; $display("FAIL underrun_cnt: got %0d expected %0d", underrun_cnt, exp_under); end
   endtask

   task automatic test_auto();
      int   n;
      logic t, em;
      empty_force = 1'b0;
      btn_auto = 1'b1;
      for (int i = 0; i < 10; i++) step();
      btn_auto = 1'b0;
      for (int i = 0; i < 12; i++) step();
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL auto_enter: got %0d expected 1", state); end
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         checks++; if (rReq !== 1'b1) begin errors++; $display("FAIL auto_tick[%0d]: got %b expected 1", k, rReq); end
         n = 0;
         for (int i = 0; i < 9; i++) begin step(); n += int'(rReq); end
         checks++; if (n != 0) begin errors++; $display("FAIL auto_idle[%0d]: got %0d pulses expected 0", k, n); end
      end
      empty_force = 1'b1;
      n = 0;
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         n += int'(rReq);
         for (int i = 0; i < 9; i++) begin step(); n += int'(rReq); end
      end
      btn_rd = 1'b1;
      for (int i = 0; i < 10; i++) begin step(); n += int'(rReq); end
      btn_rd = 1'b0;
      for (int i = 0; i < 12; i++) begin step(); n += int'(rReq); end
      checks++; if (n != 0) begin errors++; $display("FAIL auto_empty_rreq: got %0d pulses expected 0", n); end
      checks++; if (underrun_cnt !== 8'(exp_under)) begin errors++; $display("FAIL auto_underrun: got %0d expected %0d", underrun_cnt, exp_under); end
      for (int i = 0; i < 100; i++) begin
         t  = ($urandom_range(0, 3) == 0);
         em = 1'($urandom_range(0, 1));
         tick = t;
         empty_force = em;
         step();
         checks++; if (rReq !== (t & ~em)) begin errors++; $display("FAIL auto_rand[%0d]: got %b expected %b", i, rReq, t & ~em); end
      end
      tick = 1'b0;
      btn_auto = 1'b1;
      for (int i = 0; i < 10; i++) step();
      btn_auto = 1'b0;
      for (int i = 0; i < 12; i++) step();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL auto_exit: got %0d expected 0", state); end
      checks++; if (underrun_cnt !== 8'(exp_under)) begin errors++; $display("FAIL auto_underrun_end: got %0d expected %0d", underrun_cnt, exp_under); end
   endtask

   task automatic fill_model(input int n);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         step();
         rx_valid = 1'b0;
         step();
      end
   endtask

   task automatic test_flush();
      int   e, x, n;
      logic wseen;
      logic rr [0:39];
      do_reset();
      use_model = 1'b1;
      fill_model(3);
      checks++; if (m_cnt != 3) begin errors++; $display("FAIL flush_fill: got %0d entries expected 3", m_cnt); end
      e = -1;
      x = -1;
      wseen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         btn_wr = (i < 10);
         btn_rd = (i < 10);
         rx_valid = (e >= 0 && i == e + 1);
         step();
         rr[i] = rReq;
         if (wReq) wseen = 1'b1;
         if (e < 0 && state == 2'd2) e = i;
         if (e >= 0 && x < 0 && i > e && state == 2'd0) x = i;
      end
      rx_valid = 1'b0;
      exp_drop++;
      checks++; if (e < 0) begin errors++; $display("FAIL flush_entry: got no entry expected state 2"); end
      if (e >= 0 && e + 8 < 40) begin
         for (int j = 0; j <= 8; j++) begin
            checks++; if (rr[e+j] !== ((j == 1 || j == 3 || j == 5) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL flush_rreq[entry+%0d]: got %b", j, rr[e+j]); end
         end
         checks++; if (x != e + 7) begin errors++; $display("FAIL flush_exit: got offset %0d expected 7", x - e); end
      end
      checks++; if (m_cnt != 0) begin errors++; $display("FAIL flush_model_empty: got %0d entries expected 0", m_cnt); end
      checks++; if (wseen !== 1'b0) begin errors++; $display("FAIL flush_wreq: got 1 expected 0"); end
      checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL flush_drop: got %0d expected %0d", drop_cnt, exp_drop); end
      checks++; if (underrun_cnt !== 8'(exp_under)) begin errors++; $display("FAIL flush_underrun: got %0d expected %0d", underrun_cnt, exp_under); end
      // Reset in the middle of a flush must abandon it immediately.
      fill_model(3);
      btn_wr = 1'b1;
      btn_rd = 1'b1;
      e = -1;
      for (int i = 0; i < 20 && e < 0; i++) begin
         step();
         if (state == 2'd2) e = i;
      end
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      btn_wr = 1'b0;
      btn_rd = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_flush_state: got %0d expected 0", state); end
      n = 0;
      for (int i = 0; i < 10; i++) begin step(); n += int'(rReq); end
      checks++; if (n != 0 || e < 0) begin errors++; $display("FAIL rst_flush_rreq: got %0d pulses (entry %0d) expected 0", n, e); end
      use_model = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      full_force = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'b1;
         step();
         rx_valid = 1'b0;
         step();
      end
      checks++; if (drop2 !== 2'd3) begin errors++; $display("FAIL sat_drop2: got %0d expected 3", drop2); end
      checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL sat_drop8: got %0d expected 5", drop_cnt); end
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      step();
      checks++; if (drop2 !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d expected 3", drop2); end
      full_force = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_path();
      test_random_writes();
      test_button_read();
      test_auto();
      test_flush();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
